// File: rtl/div_sequencer_if.sv
// Control/status bundle for div_sequencer: table writes, sequence control and divider outputs.
interface div_sequencer_if #(
    parameter int unsigned MAX_DIVIDER = 50_000_000,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DWELL_W     = 8
);
    localparam int unsigned DIV_W = $clog2(MAX_DIVIDER + 1);
    localparam int unsigned AW    = $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [DIV_W-1:0]   wr_div;
    logic [DWELL_W-1:0] wr_dwell;
    logic [AW:0]        seq_len;
    logic               loop;
    logic               start;
    logic               stop;
    logic [DIV_W-1:0]   div;
    logic               div_load;
    logic [AW-1:0]      step_idx;
    logic               active;
    logic               done;
    logic               phase;

    modport master (
        output wr_en, wr_addr, wr_div, wr_dwell, seq_len, loop, start, stop,
        input  div, div_load, step_idx, active, done, phase
    );

    modport slave (
        input  wr_en, wr_addr, wr_div, wr_dwell, seq_len, loop, start, stop,
        output div, div_load, step_idx, active, done, phase
    );
endinterface

// File: rtl/div_sequencer.sv
// Plays a table of (ratio, dwell) entries; each entry lasts div*dwell inclk cycles.
// Optional divided-clock phase output enabled by defining DIV_SEQ_PHASE_EN.
module div_sequencer #(
    parameter int unsigned MAX_DIVIDER = 50_000_000,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DWELL_W     = 8
) (
    input  logic           inclk,
    input  logic           rst,
    div_sequencer_if.slave bus
);
    localparam int unsigned DIV_W = $clog2(MAX_DIVIDER + 1);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state;
    logic [DIV_W-1:0]   tbl_div   [DEPTH];
    logic [DWELL_W-1:0] tbl_dwell [DEPTH];

    logic [DIV_W-1:0]   div_r;
    logic               div_load_r;
    logic [AW-1:0]      step_idx_r;
    logic               active_r;
    logic               done_r;
    logic [DIV_W-1:0]   per_cnt;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [LW-1:0]      len_r;

    logic [DIV_W-1:0]   div_m1;
    logic               per_end;
    logic               entry_end;
    logic               last_entry;
    logic               start_ok;
    logic               advance;
    logic               do_load;
    logic [AW-1:0]      load_idx;
    logic [DIV_W-1:0]   load_div;
    logic [DWELL_W-1:0] load_dwell;
    logic [LW-1:0]      seq_len_clamped;

    // A stored ratio of 0 behaves as 1, so its last count is also 0.
    assign div_m1     = (div_r == '0) ? '0 : div_r - DIV_W'(1);
    assign per_end    = (per_cnt == div_m1);
    assign entry_end  = per_end && (dwell_cnt == '0);
    assign last_entry = ({1'b0, step_idx_r} == len_r - LW'(1));

    assign start_ok = (state == StIdle) && bus.start && !bus.stop && (bus.seq_len != '0);
    assign advance  = (state == StRun) && !bus.stop && entry_end && (!last_entry || bus.loop);
    assign do_load  = start_ok || advance;
    assign load_idx = (start_ok || last_entry) ? '0 : step_idx_r + AW'(1);

    assign load_div   = tbl_div[load_idx];
    assign load_dwell = tbl_dwell[load_idx];

    assign seq_len_clamped = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;

    // Loads read the pre-write contents when the same index is written on the load edge.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                tbl_div[i]   <= '0;
                tbl_dwell[i] <= '0;
            end
        end else if (bus.wr_en) begin
            tbl_div[bus.wr_addr]   <= bus.wr_div;
            tbl_dwell[bus.wr_addr] <= bus.wr_dwell;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            div_r      <= '0;
            div_load_r <= 1'b0;
            step_idx_r <= '0;
            active_r   <= 1'b0;
            done_r     <= 1'b0;
            per_cnt    <= '0;
            dwell_cnt  <= '0;
            len_r      <= '0;
        end else begin
            div_load_r <= 1'b0;
            done_r     <= 1'b0;
            if (bus.stop) begin
                state    <= StIdle;
                active_r <= 1'b0;
                per_cnt  <= '0;
            end else if (do_load) begin
                state      <= StRun;
                active_r   <= 1'b1;
                div_r      <= load_div;
                dwell_cnt  <= (load_dwell == '0) ? '0 : load_dwell - DWELL_W'(1);
                per_cnt    <= '0;
                step_idx_r <= load_idx;
                div_load_r <= 1'b1;
                if (start_ok) begin
                    len_r <= seq_len_clamped;
                end
            end else if (state == StRun) begin
                if (entry_end) begin
                    state    <= StIdle;
                    active_r <= 1'b0;
                    done_r   <= 1'b1;
                    per_cnt  <= '0;
                end else if (per_end) begin
                    per_cnt   <= '0;
                    dwell_cnt <= dwell_cnt - DWELL_W'(1);
                end else begin
                    per_cnt <= per_cnt + DIV_W'(1);
                end
            end
        end
    end

    assign bus.div      = div_r;
    assign bus.div_load = div_load_r;
    assign bus.step_idx = step_idx_r;
    assign bus.active   = active_r;
    assign bus.done     = done_r;

`ifdef DIV_SEQ_PHASE_EN
    logic             phase_r;
    logic [DIV_W-1:0] half_cur;
    logic [DIV_W-1:0] half_new;

    assign half_cur = div_r >> 1;
    assign half_new = load_div >> 1;

    // Registered against the count the run will hold next cycle, so phase lines up with per_cnt.
    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
        end else if (bus.stop) begin
            phase_r <= 1'b0;
        end else if (do_load) begin
            phase_r <= (half_new != '0);
        end else if ((state != StRun) || entry_end) begin
            phase_r <= 1'b0;
        end else if (per_end) begin
            phase_r <= (half_cur != '0);
        end else begin
            phase_r <= ((per_cnt + DIV_W'(1)) < half_cur);
        end
    end

    assign bus.phase = phase_r;
`else
    assign bus.phase = 1'b0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed scenarios plus random traffic against
// an entry-level model (each entry is a span of eff_div*eff_dwell cycles).
module tb_div_sequencer;
    localparam int unsigned MAX_DIVIDER = 50_000_000;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned DWELL_W     = 8;
    localparam int unsigned DIV_W       = $clog2(MAX_DIVIDER + 1);
    localparam int unsigned AW          = $clog2(DEPTH);

    logic inclk = 1'b0;
    logic rst;

    div_sequencer_if #(
        .MAX_DIVIDER(MAX_DIVIDER),
        .DEPTH      (DEPTH),
        .DWELL_W    (DWELL_W)
    ) bus ();

    div_sequencer #(
        .MAX_DIVIDER(MAX_DIVIDER),
        .DEPTH      (DEPTH),
        .DWELL_W    (DWELL_W)
    ) dut (
        .inclk(inclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 inclk = ~inclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: table contents and position inside the current entry.
    int m_tdiv [DEPTH];
    int m_tdw  [DEPTH];
    bit m_active;
    int m_idx, m_len, m_div, m_pos, m_span;
    bit m_load, m_done;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_tdiv[i] = 0;
            m_tdw[i]  = 0;
        end
        m_active = 0; m_idx = 0; m_len = 0; m_div = 0; m_pos = 0; m_span = 1;
        m_load = 0; m_done = 0;
    endtask

    task automatic model_load(input int i);
        m_idx    = i;
        m_div    = m_tdiv[i];
        m_span   = eff(m_tdiv[i]) * eff(m_tdw[i]);
        m_pos    = 0;
        m_load   = 1;
        m_active = 1;
    endtask

    task automatic model_step();
        m_load = 0;
        m_done = 0;
        if (bus.stop) begin
            m_active = 0;
        end else if (!m_active) begin
            if (bus.start && bus.seq_len != 0) begin
                m_len = (int'(bus.seq_len) > int'(DEPTH)) ? int'(DEPTH) : int'(bus.seq_len);
                model_load(0);
            end
        end else begin
            m_pos++;
            if (m_pos == m_span) begin
                if (m_idx < m_len - 1) model_load(m_idx + 1);
                else if (bus.loop) model_load(0);
                else begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end
        if (bus.wr_en) begin
            m_tdiv[bus.wr_addr] = int'(bus.wr_div);
            m_tdw[bus.wr_addr]  = int'(bus.wr_dwell);
        end
    endtask

    task automatic check_outputs(input string pfx);
        logic exp_phase;
`ifdef DIV_SEQ_PHASE_EN
        exp_phase = m_active && ((m_pos % eff(m_div)) < (m_div / 2));
`else
        exp_phase = 1'b0;
`endif
        check_eq({pfx, ".div"},      32'(bus.div),      32'(m_div));
        check_eq({pfx, ".div_load"}, 32'(bus.div_load), 32'(m_load));
        check_eq({pfx, ".step_idx"}, 32'(bus.step_idx), 32'(m_idx));
        check_eq({pfx, ".active"},   32'(bus.active),   32'(m_active));
        check_eq({pfx, ".done"},     32'(bus.done),     32'(m_done));
        check_eq({pfx, ".phase"},    32'(bus.phase),    32'(exp_phase));
    endtask

    // Inputs change only around negedge; model and DUT both sample at posedge.
    task automatic cycle();
        @(posedge inclk);
        model_step();
        @(negedge inclk);
        check_outputs("cyc");
    endtask

    task automatic clear_inputs();
        bus.wr_en = 0; bus.start = 0; bus.stop = 0;
    endtask

    task automatic write_entry(input int a, input int d, input int w);
        bus.wr_en    = 1;
        bus.wr_addr  = AW'(a);
        bus.wr_div   = DIV_W'(d);
        bus.wr_dwell = DWELL_W'(w);
        cycle();
        bus.wr_en = 0;
    endtask

    task automatic begin_seq(input int len, input bit lp);
        bus.seq_len = (AW + 1)'(len);
        bus.loop    = lp;
        bus.start   = 1;
        cycle();
        bus.start = 0;
    endtask

    int c4, c3, c6, n_done;
    int load_idx_q[$];
    int exp_idx[4] = '{0, 1, 0, 1};

    initial begin
        rst = 1;
        clear_inputs();
        bus.wr_addr = '0; bus.wr_div = '0; bus.wr_dwell = '0;
        bus.seq_len = '0; bus.loop = 0;
        model_reset();
        repeat (2) @(negedge inclk);
        check_outputs("reset");
        rst = 0;

        // Async reset mid-run clears outputs at once and wipes the table.
        write_entry(0, 3, 2);
        begin_seq(1, 1);
        repeat (4) cycle();
        rst = 1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge inclk);
        rst = 0;
        begin_seq(1, 0);
        check_eq("cleared_div", 32'(bus.div), 32'd0);
        check_eq("cleared_active", 32'(bus.active), 32'd1);
        repeat (3) cycle();

        // Two-entry non-looping run: 8 cycles of 4, 3 cycles of 3, then done.
        write_entry(0, 4, 2);
        write_entry(1, 3, 1);
        c4 = 0; c3 = 0; n_done = 0;
        begin_seq(2, 0);
        for (int k = 0; k < 14; k++) begin
            if (bus.active && bus.div == 4) c4++;
            if (bus.active && bus.div == 3) c3++;
            if (bus.done) n_done++;
            cycle();
        end
        check_eq("span_div4", 32'(c4), 32'd8);
        check_eq("span_div3", 32'(c3), 32'd3);
        check_eq("done_pulses", 32'(n_done), 32'd1);
        check_eq("idle_after", 32'(bus.active), 32'd0);

        // Looping run: loads every 8/3 cycles, indices alternate.
        load_idx_q.delete();
        begin_seq(2, 1);
        for (int k = 0; k < 33; k++) begin
            if (bus.div_load) load_idx_q.push_back(int'(bus.step_idx));
            if (k < 32) cycle();
        end
        check_eq("loop_loads", 32'(load_idx_q.size()), 32'd6);
        for (int i = 0; i < 4 && i < load_idx_q.size(); i++)
            check_eq("loop_idx", 32'(load_idx_q[i]), 32'(exp_idx[i]));
        bus.stop = 1;
        cycle();
        bus.stop = 0;
        check_eq("loop_stopped", 32'(bus.active), 32'd0);

        // Stop on cycle 5 of entry 0; then start+stop together stays idle.
        begin_seq(2, 0);
        repeat (4) cycle();
        bus.stop = 1;
        cycle();
        check_eq("stop_active", 32'(bus.active), 32'd0);
        check_eq("stop_no_done", 32'(bus.done), 32'd0);
        bus.start = 1;
        cycle();
        clear_inputs();
        check_eq("start_stop_idle", 32'(bus.active), 32'd0);

        // Rewrite entry 1 while entry 0 plays.
        c6 = 0;
        begin_seq(2, 0);
        write_entry(1, 6, 1);
        for (int k = 0; k < 20; k++) begin
            if (bus.active && bus.div == 6) c6++;
            cycle();
        end
        check_eq("rewritten_span", 32'(c6), 32'd6);

        // Write to index 0 on its own load edge: old value plays.
        bus.wr_en = 1; bus.wr_addr = '0; bus.wr_div = DIV_W'(2); bus.wr_dwell = DWELL_W'(1);
        begin_seq(2, 0);
        bus.wr_en = 0;
        check_eq("old_on_load", 32'(bus.div), 32'd4);
        repeat (20) cycle();

        // Phase shapes for ratios 4 and 5 via the model.
        write_entry(0, 4, 1);
        write_entry(1, 5, 2);
        begin_seq(2, 1);
        repeat (30) cycle();
        bus.stop = 1;
        cycle();
        bus.stop = 0;

        // Random traffic with one async reset in the middle.
        for (int k = 0; k < 4000; k++) begin
            bus.wr_en    = ($urandom_range(0, 3) == 0);
            bus.wr_addr  = AW'($urandom_range(0, DEPTH - 1));
            bus.wr_div   = DIV_W'($urandom_range(0, 6));
            bus.wr_dwell = DWELL_W'($urandom_range(0, 3));
            bus.seq_len  = (AW + 1)'($urandom_range(0, 2 * DEPTH - 1));
            bus.loop     = $urandom_range(0, 1);
            bus.start    = ($urandom_range(0, 2) == 0);
            bus.stop     = ($urandom_range(0, 39) == 0);
            if (k == 2000) begin
                rst = 1;
                #1;
                model_reset();
                check_outputs("rand_rst");
                @(negedge inclk);
                rst = 0;
            end else begin
                cycle();
            end
        end
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Programmable step sequencer for the clock divider datapath: holds a small table of (divide ratio, dwell) entries and plays them out, presenting the active ratio on `div` for a downstream frequency divider. Each entry stays active for exactly `div × dwell` `inclk` cycles, so ratio changes land on divided-period boundaries. Used to produce LED flash patterns and tone sweeps without CPU or switch intervention.

## Interface
Parameters:
- `MAX_DIVIDER`, 50_000_000, largest supported ratio; DIV_W = bit count of MAX_DIVIDER (26 for default)
- `DEPTH`, 8, table entries (power of two, ≥2); AW = log2(DEPTH)
- `DWELL_W`, 8, width of dwell field

Ports:
- `inclk`  in  1  clock
- `rst`  in  1  reset rst, asynchronous, active-high
- `wr_en`  in  1  table write strobe
- `wr_addr`  in  AW  table write index
- `wr_div`  in  DIV_W  ratio to store
- `wr_dwell`  in  DWELL_W  number of divided periods to store
- `seq_len`  in  AW+1  entries to play (1..DEPTH), sampled on start
- `loop`  in  1  replay from entry 0 after last entry; sampled every entry boundary
- `start`  in  1  begin sequence (level-sampled, ignored while active)
- `stop`  in  1  abort sequence
- `div`  out  DIV_W  active ratio for downstream divider
- `div_load`  out  1  one-cycle pulse: `div` changed this cycle
- `step_idx`  out  AW  index of active entry
- `active`  out  1  sequence running
- `done`  out  1  one-cycle pulse: non-looping sequence completed
- `phase`  out  1  divided-clock phase (see Configuration)

## Operation
- States: IDLE, RUN. Counters: `per_cnt` (DIV_W), `dwell_cnt` (DWELL_W), `len_r` (AW+1).
- Table: DEPTH registers, cleared to 0 on reset; write at posedge when `wr_en`. Writes allowed in any state; a written entry takes effect next time it is loaded. Simultaneous write and load of same index loads the old value.
- Effective ratio: stored div 0 treated as 1. Effective dwell: 0 treated as 1.
- IDLE, `start`=1, `stop`=0, `seq_len`≠0: load entry 0 (`div`, `dwell_cnt`=dwell−1, `per_cnt`=0), `step_idx`=0, `len_r`=`seq_len` clamped to DEPTH, `div_load`=1, go RUN. `seq_len`=0: start ignored.
- RUN each cycle: `per_cnt` increments; when `per_cnt` = div−1 it wraps to 0 (period end).
- Period end with `dwell_cnt`≠0: decrement `dwell_cnt`.
- Period end with `dwell_cnt`=0 (entry end): if `step_idx`<`len_r`−1 load next entry; else if `loop` load entry 0; else go IDLE, pulse `done`. Every load pulses `div_load`.
- `stop`=1: go IDLE next edge from any state, no `done`; highest priority over start and entry end.
- IDLE: `div` holds last value, `per_cnt`=0, `active`=0.
- Arithmetic unsigned; comparisons at full DIV_W; no wrap beyond div−1.

## Timing
- Reset values: `div`=0, `div_load`=0, `step_idx`=0, `active`=0, `done`=0, `phase`=0, all counters 0, state IDLE.
- Start latency: start sampled at edge E0 → `div`, `step_idx`, `active`=1, `div_load`=1 valid after E0.
- Entry i occupies exactly div_i × dwell_i cycles; next entry visible the cycle after last cycle of entry i, no gap cycle.
- `done` and `active` falling occur on the same edge, one cycle after final cycle of last entry.
- `stop` at edge E → `active`=0 after E; mid-period abort is allowed.
- Async `rst` mid-run forces reset values immediately, table cleared.

## Configuration
- `DIV_SEQ_PHASE_EN` defined: `phase` registered = 1 while `per_cnt` < (div>>1), else 0, during RUN; 0 in IDLE. For div=1 `phase`=0. Provides divider-equivalent output aligned to entry boundaries.
- Undefined: `phase` tied 0, no compare logic.

## Test plan
- Reset: assert `rst` mid-run → all outputs 0 immediately; after release, `start` with `seq_len`=1 loads `div`=0→effective 1, table cleared.
- Table {0:(div 4,dwell 2),1:(div 3,dwell 1)}, `seq_len`=2, `loop`=0, start → `div`=4 for 8 cycles, `div`=3 for 3 cycles, `done` pulse next cycle, `active`=0.
- Same table, `loop`=1 → pattern 4×8 cycles, 3×3 cycles repeats; `div_load` pulses every 8/3 cycles; `step_idx` 0,1,0,1.
- `stop` asserted cycle 5 of entry 0 → `active`=0 next cycle, no `done`; `start` and `stop` together in IDLE → stays IDLE.
- Write entry 1 to (div 6,dwell 1) while entry 0 running → entry 1 plays 6 cycles; write to index 0 on load cycle of 0 → old value used.
- `DIV_SEQ_PHASE_EN`, div 4 → `phase` 1,1,0,0 repeating; div 5 → 1,1,0,0,0; macro off → `phase` constant 0.
